// File: rtl/hog_block_stream.sv
// Streams 2x2 HOG blocks from a raster-ordered cell histogram stream.
// A one-row line buffer supplies the upper cells of each block.
module hog_block_stream #(
  parameter int unsigned DATA_W  = 288,
  parameter int unsigned CELLS_W = 80,
  parameter int unsigned CELLS_H = 60,
  parameter int unsigned ID_W    = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic              i_sof,
  input  logic [DATA_W-1:0] bin,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [ID_W-1:0]   bid,
  output logic [DATA_W-1:0] fea_a,
  output logic [DATA_W-1:0] fea_b,
  output logic [DATA_W-1:0] fea_c,
  output logic [DATA_W-1:0] fea_d,
  output logic              o_frame_done
);

  localparam int unsigned COL_W    = (CELLS_W > 2) ? $clog2(CELLS_W) : 1;
  localparam int unsigned ROW_W    = (CELLS_H > 2) ? $clog2(CELLS_H) : 1;
  localparam int unsigned LAST_BID = (CELLS_W - 1) * (CELLS_H - 1) - 1;

  typedef enum logic {ROW0, RUN} state_t;

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d, cur_col;
  logic [ROW_W-1:0]  row_q, row_d, cur_row;
  logic [ID_W-1:0]   cnt_q, cnt_d, bid_q, bid_d;
  logic              o_valid_q, o_valid_d;
  logic [DATA_W-1:0] fea_a_q, fea_a_d, fea_b_q, fea_b_d;
  logic [DATA_W-1:0] fea_c_q, fea_c_d, fea_d_q, fea_d_d;
  logic [DATA_W-1:0] left_q, left_d, upleft_q, upleft_d;
  logic [DATA_W-1:0] lb_q [CELLS_W];
  logic [DATA_W-1:0] lb_rd;
  logic              accept, produce, last_cell, col_last;

  assign i_ready = !rst && (!o_valid_q || o_ready);
  assign accept  = i_valid && i_ready;

  // An accepted start-of-frame cell overrides the position counters.
  assign cur_col   = i_sof ? '0 : col_q;
  assign cur_row   = i_sof ? '0 : row_q;
  assign col_last  = (cur_col == COL_W'(CELLS_W - 1));
  assign last_cell = col_last && (cur_row == ROW_W'(CELLS_H - 1));
  assign lb_rd     = lb_q[cur_col];
  assign produce   = accept && (state_q == RUN) && !i_sof && (col_q != '0);

  assign o_valid      = o_valid_q;
  assign bid          = bid_q;
  assign fea_a        = fea_a_q;
  assign fea_b        = fea_b_q;
  assign fea_c        = fea_c_q;
  assign fea_d        = fea_d_q;
  assign o_frame_done = o_valid_q && o_ready && (bid_q == ID_W'(LAST_BID));

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    bid_d     = bid_q;
    o_valid_d = o_valid_q;
    fea_a_d   = fea_a_q;
    fea_b_d   = fea_b_q;
    fea_c_d   = fea_c_q;
    fea_d_d   = fea_d_q;
    left_d    = left_q;
    upleft_d  = upleft_q;

    if (o_ready) o_valid_d = 1'b0;

    if (accept) begin
      left_d   = bin;
      upleft_d = lb_rd;

      if (col_last) begin
        col_d = '0;
        row_d = (cur_row == ROW_W'(CELLS_H - 1)) ? '0 : cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
        row_d = cur_row;
      end

      if (i_sof) cnt_d = '0;

      // Load a new block; this also covers a simultaneous drain.
      if (produce) begin
        o_valid_d = 1'b1;
        bid_d     = cnt_q;
        fea_a_d   = upleft_q;
        fea_b_d   = lb_rd;
        fea_c_d   = left_q;
        fea_d_d   = bin;
        cnt_d     = (cnt_q == ID_W'(LAST_BID)) ? '0 : cnt_q + ID_W'(1);
      end

      if (last_cell) cnt_d = '0;

      case (state_q)
        ROW0:    if (col_last) state_d = RUN;
        RUN:     if (i_sof || last_cell) state_d = ROW0;
        default: state_d = ROW0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ROW0;
      col_q     <= '0;
      row_q     <= '0;
      cnt_q     <= '0;
      bid_q     <= '0;
      o_valid_q <= 1'b0;
      fea_a_q   <= '0;
      fea_b_q   <= '0;
      fea_c_q   <= '0;
      fea_d_q   <= '0;
      left_q    <= '0;
      upleft_q  <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      bid_q     <= bid_d;
      o_valid_q <= o_valid_d;
      fea_a_q   <= fea_a_d;
      fea_b_q   <= fea_b_d;
      fea_c_q   <= fea_c_d;
      fea_d_q   <= fea_d_d;
      left_q    <= left_d;
      upleft_q  <= upleft_d;
    end
  end

  // Previous-row storage; never read before the row has been written.
  always_ff @(posedge clk) begin
    if (accept) lb_q[cur_col] <= bin;
  end

endmodule

// File: tb/tb_hog_block_stream.sv
// Directed and randomized-handshake bench for hog_block_stream on a 4x3 cell grid.
module tb_hog_block_stream;

  localparam int unsigned DW = 32;
  localparam int unsigned IW = 4;

  logic          clk = 1'b0;
  logic          rst, i_valid, i_ready, i_sof, o_valid, o_ready, o_frame_done;
  logic [DW-1:0] bin, fea_a, fea_b, fea_c, fea_d;
  logic [IW-1:0] bid;

  hog_block_stream #(.DATA_W(DW), .CELLS_W(4), .CELLS_H(3), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_sof(i_sof),
    .bin(bin), .o_valid(o_valid), .o_ready(o_ready), .bid(bid),
    .fea_a(fea_a), .fea_b(fea_b), .fea_c(fea_c), .fea_d(fea_d),
    .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  typedef struct { int sof; int val; } cell_t;
  typedef struct { int bid; int a; int b; int c; int d; int done; } blk_t;

  cell_t tx_q[$];
  blk_t  exp_q[$];
  blk_t  rx_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    stall_hits;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Queue a 12-cell frame with bin = base + k and its 6 hand-derived blocks.
  task automatic add_frame(input int base, input int sof);
    int r, c, a;
    for (int k = 0; k < 12; k++) tx_q.push_back('{sof: (k == 0) ? sof : 0, val: base + k});
    for (int n = 0; n < 6; n++) begin
      r = n / 3 + 1;
      c = n % 3 + 1;
      a = base + (r - 1) * 4 + (c - 1);
      exp_q.push_back('{bid: n, a: a, b: a + 1, c: base + r * 4 + c - 1,
                        d: base + r * 4 + c, done: (n == 5) ? 1 : 0});
    end
  endtask

  // Drive tx_q and collect handshaken blocks; optional 5-cycle stall on bid 2.
  task automatic stream(input int vpct, input int rpct, input bit do_stall, input int max_cyc);
    int    cyc = 0;
    int    viol = 0;
    bit    hold = 1'b0;
    logic [IW-1:0] p_bid;
    logic [DW-1:0] p_a, p_b, p_c, p_d;
    stall_hits = 0;
    forever begin
      @(negedge clk);
      if ((tx_q.size() == 0 && !o_valid) || cyc >= max_cyc) break;
      cyc++;
      if (tx_q.size() > 0 && $urandom_range(0, 99) < 32'(vpct)) begin
        i_valid = 1'b1;
        i_sof   = tx_q[0].sof[0];
        bin     = DW'(tx_q[0].val);
      end else begin
        i_valid = 1'b0;
        i_sof   = 1'b0;
      end
      o_ready = ($urandom_range(0, 99) < 32'(rpct));
      if (do_stall && stall_hits < 5 && (stall_hits > 0 || (o_valid && bid == IW'(2)))) begin
        o_ready = 1'b0;
        stall_hits++;
      end
      #1;
      if (do_stall && stall_hits > 0 && !o_ready) begin
        check("stall_i_ready", 32'(i_ready), 0);
        check("stall_bid", 32'(bid), 2);
        check("stall_a", fea_a, 2);
        check("stall_b", fea_b, 3);
        check("stall_c", fea_c, 6);
        check("stall_d", fea_d, 7);
      end
      if (i_ready !== (!o_valid || o_ready)) viol++;
      if (hold && (!o_valid || bid !== p_bid || fea_a !== p_a || fea_b !== p_b ||
                   fea_c !== p_c || fea_d !== p_d)) viol++;
      if (o_frame_done && !(o_valid && o_ready)) viol++;
      hold  = o_valid && !o_ready;
      p_bid = bid; p_a = fea_a; p_b = fea_b; p_c = fea_c; p_d = fea_d;
      if (o_valid && o_ready)
        rx_q.push_back('{bid: int'(bid), a: int'(fea_a), b: int'(fea_b), c: int'(fea_c),
                         d: int'(fea_d), done: int'(o_frame_done)});
      if (i_valid && i_ready) void'(tx_q.pop_front());
    end
    i_valid = 1'b0;
    i_sof   = 1'b0;
    o_ready = 1'b0;
    check("timeout", 32'(cyc >= max_cyc), 0);
    check("handshake_rules", 32'(viol), 0);
    tx_q.delete();
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_bid"},  32'(rx_q[i].bid),  32'(exp_q[i].bid));
      check({tag, "_a"},    32'(rx_q[i].a),    32'(exp_q[i].a));
      check({tag, "_b"},    32'(rx_q[i].b),    32'(exp_q[i].b));
      check({tag, "_c"},    32'(rx_q[i].c),    32'(exp_q[i].c));
      check({tag, "_d"},    32'(rx_q[i].d),    32'(exp_q[i].d));
      check({tag, "_done"}, 32'(rx_q[i].done), 32'(exp_q[i].done));
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_sof = 1'b0; bin = '0; o_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_i_ready", 32'(i_ready), 0);
    check("rst_o_valid", 32'(o_valid), 0);
    check("rst_bid", 32'(bid), 0);
    check("rst_fea_a", fea_a, 0);
    check("rst_fea_d", fea_d, 0);
    check("rst_done", 32'(o_frame_done), 0);
    rst = 1'b0;
    #1;
    check("idle_i_ready", 32'(i_ready), 1);

    add_frame(0, 1);
    stream(100, 100, 1'b0, 200);
    compare("frame");

    add_frame(0, 1);
    stream(100, 100, 1'b1, 200);
    check("stall_len", 32'(stall_hits), 5);
    compare("stall");

    add_frame(0, 1);
    add_frame(100, 1);
    stream(100, 100, 1'b0, 200);
    compare("b2b");

    // Mid-frame resync at k=6: one block from the old frame, then a fresh frame.
    for (int k = 0; k < 6; k++) tx_q.push_back('{sof: (k == 0) ? 1 : 0, val: k});
    exp_q.push_back('{bid: 0, a: 0, b: 1, c: 4, d: 5, done: 0});
    add_frame(6, 1);
    stream(100, 100, 1'b0, 200);
    compare("resync");

    // Reset while a block is stalled; next frame carries no i_sof.
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      i_valid = 1'b1; i_sof = (k == 0); bin = DW'(k); o_ready = 1'b0;
      @(negedge clk);
    end
    i_valid = 1'b0; i_sof = 1'b0;
    #1;
    check("pre_rst_valid", 32'(o_valid), 1);
    check("pre_rst_bid", 32'(bid), 0);
    check("pre_rst_d", fea_d, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_valid", 32'(o_valid), 0);
    check("post_rst_fea_a", fea_a, 0);
    check("post_rst_i_ready", 32'(i_ready), 1);
    add_frame(0, 0);
    stream(100, 100, 1'b0, 200);
    compare("after_rst");

    add_frame(200, 1);
    add_frame(300, 1);
    add_frame(400, 1);
    stream(60, 50, 1'b0, 3000);
    compare("random");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
